bnn_popaccum: RTL

Multi-channel XNOR-popcount accumulator and binary activation stage for the BNN datapath. It generalises the single-bit serial accumulator. Each beat delivers a W-bit slice per channel for C channels. The block adds each slice's popcount into that channel's counter over a fixed frame of N beats. At frame end it presents the counts and the thresholded activation bits through a valid/ready output handshake. It sits between the XNOR array and the next layer's input buffer.

---
 rtl/bnn_popaccum_if.sv | 27 ++
 rtl/bnn_popaccum.sv | 111 +++++++++++
 2 files changed

// File: rtl/bnn_popaccum_if.sv
// Stream bundle for bnn_popaccum: input beat handshake and frame result handshake.
// The master side feeds beats and accepts results; the slave side is the accumulator.
interface bnn_popaccum_if #(
    parameter int W = 8,
    parameter int C = 4,
    parameter int N = 16
);
    localparam int CW = $clog2(N*W+1);

    logic               in_valid;
    logic               in_ready;
    logic [C*W-1:0]     in_data;
    logic               out_valid;
    logic               out_ready;
    logic [C*CW-1:0]    out_acc;
    logic [C-1:0]       out_act;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_acc, out_act
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_acc, out_act
    );
endinterface

// File: rtl/bnn_popaccum.sv
// Multi-channel XNOR-popcount accumulator with binary activation.
// Collects N beats of C W-bit slices, then holds per-channel counts and threshold bits.
module bnn_popaccum #(
    parameter int W  = 8,
    parameter int C  = 4,
    parameter int N  = 16,
    parameter int TH = (N*W)/2,
    localparam int CW = $clog2(N*W+1),
    localparam int BW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    bnn_popaccum_if.slave bus,
    output logic [BW-1:0] beat_cnt
);

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam logic [31:0] TH_U = 32'(TH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(N-1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [C-1:0][CW-1:0]   r_acc;
    logic [C-1:0][CW-1:0]   r_out_acc;
    logic [C-1:0]           r_out_act;
    logic [BW-1:0]          r_beat_cnt;
    logic [C-1:0][CW-1:0]   w_sum;
    logic [C-1:0]           w_act;
    logic                   w_accept;
    logic                   w_last;

    function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    assign w_accept = bus.in_valid && (r_state == S_ACC);
    assign w_last   = (r_beat_cnt == LAST_BEAT);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_sum = '0;
        w_act = '0;
        for (int c = 0; c < C; c++) begin
            w_sum[c] = r_acc[c] + popcount(bus.in_data[c*W +: W]);
            w_act[c] = (32'(w_sum[c]) >= TH_U);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = S_ACC;
        end else begin
            case (r_state)
                S_ACC:   if (w_accept && w_last) w_state_nxt = S_OUT;
                S_OUT:   if (bus.out_ready)      w_state_nxt = S_ACC;
                default: w_state_nxt = S_ACC;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: the accumulator array is small and must start each frame at zero, so it is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_beat_cnt <= '0;
            r_out_acc  <= '0;
            r_out_act  <= '0;
        end else if (clear) begin
            // Result registers keep their contents; only the frame in progress is dropped.
            r_acc      <= '0;
            r_beat_cnt <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_out_acc  <= w_sum;
                r_out_act  <= w_act;
                r_acc      <= '0;
                r_beat_cnt <= '0;
            end else begin
                r_acc      <= w_sum;
                r_beat_cnt <= r_beat_cnt + BW'(1);
            end
        end
    end

    assign bus.in_ready  = (r_state == S_ACC);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_acc   = r_out_acc;
    assign bus.out_act   = r_out_act;
    assign beat_cnt      = r_beat_cnt;

endmodule
